adc_i2s_tx: RTL and testbench



---
 rtl/adc_i2s_tx.sv | 136 +++++++++++++
 tb/tb_adc_i2s_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_i2s_tx.sv
// rtl/adc_i2s_tx.sv - ADC sample FIFO and I2S/left-justified serial transmitter (option: ADC_I2S_TX_LJ_EN)
module adc_i2s_tx #(
    parameter int SAMPLE_BITLEN = 24,
    parameter int SLOT_BITS     = 32,
    parameter int BCLK_HALF     = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [SAMPLE_BITLEN-1:0]        sample_in,
    input  logic                            sample_valid,
    output logic                            i2s_bclk,
    output logic                            i2s_lrclk,
    output logic                            i2s_sdata,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_BITS);
    localparam logic [BW-1:0] DATA_LEN = BW'(SAMPLE_BITLEN);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    // Reset LRCLK matches the value the last bit of a frame would carry
`ifdef ADC_I2S_TX_LJ_EN
    localparam logic LR_RESET = 1'b1;
`else
    localparam logic LR_RESET = 1'b0;
`endif

    logic [DW-1:0]            div_cnt;
    logic [BW-1:0]            bit_cnt;
    logic [SAMPLE_BITLEN-1:0] tx_word;
    logic [SAMPLE_BITLEN-1:0] mem [FIFO_DEPTH];
    logic [LW-1:0]            wr_cnt;
    logic [LW-1:0]            rd_cnt;

    logic                     div_wrap;
    logic                     fall_evt;
    logic                     frame_start;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     do_pop;
    logic                     do_push;
    logic [BW-1:0]            bit_nxt;
    logic [BW-1:0]            lr_cnt;
    logic [BW-1:0]            pos;
    logic [SAMPLE_BITLEN-1:0] word_nxt;
    logic [SAMPLE_BITLEN-1:0] shifted;
    logic                     sdata_nxt;
    logic                     lrclk_nxt;

    assign div_wrap    = (div_cnt == DIV_LAST);
    assign fall_evt    = div_wrap & i2s_bclk;
    assign frame_start = fall_evt & (bit_cnt == BIT_LAST);
    assign fifo_level  = wr_cnt - rd_cnt;
    assign fifo_empty  = (wr_cnt == rd_cnt);
    assign fifo_full   = (fifo_level == FULL_LVL);
    assign do_pop      = frame_start & ~fifo_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign do_push     = sample_valid & (~fifo_full | do_pop);

    // Next bit position, word and the serial/LR values to present at the fall event
    always_comb begin
        bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        word_nxt  = do_pop ? mem[rd_cnt[AW-1:0]] : tx_word;
        pos       = (bit_nxt >= SLOT_LEN) ? bit_nxt - SLOT_LEN : bit_nxt;
        shifted   = word_nxt << pos;
        sdata_nxt = (pos < DATA_LEN) ? shifted[SAMPLE_BITLEN-1] : 1'b0;
`ifdef ADC_I2S_TX_LJ_EN
        lr_cnt    = bit_nxt;
`else
        lr_cnt    = (bit_nxt == BIT_LAST) ? '0 : bit_nxt + 1'b1;
`endif
        lrclk_nxt = (lr_cnt >= SLOT_LEN);
    end

    // Sample storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_cnt[AW-1:0]] <= sample_in;
        end
    end

    // BCLK divider, frame bit counter and registered serial outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            i2s_bclk  <= 1'b0;
            bit_cnt   <= BIT_LAST;
            tx_word   <= '0;
            i2s_lrclk <= LR_RESET;
            i2s_sdata <= 1'b0;
            underflow <= 1'b0;
        end else begin
            div_cnt   <= div_wrap ? '0 : div_cnt + 1'b1;
            underflow <= frame_start & fifo_empty;
            if (div_wrap) begin
                i2s_bclk <= ~i2s_bclk;
            end
            if (fall_evt) begin
                bit_cnt   <= bit_nxt;
                tx_word   <= word_nxt;
                i2s_lrclk <= lrclk_nxt;
                i2s_sdata <= sdata_nxt;
            end
        end
    end

    // FIFO write/read counters and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (do_pop) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (sample_valid & ~do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_i2s_tx.sv
// tb/tb_adc_i2s_tx.sv - directed table-driven bench for adc_i2s_tx with BCLK_HALF=2
module tb_adc_i2s_tx;

    logic        clk;
    logic        rst_n;
    logic [23:0] sample_in;
    logic        sample_valid;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        underflow;

    adc_i2s_tx #(
        .SAMPLE_BITLEN(24),
        .SLOT_BITS(32),
        .BCLK_HALF(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .i2s_bclk(i2s_bclk),
        .i2s_lrclk(i2s_lrclk),
        .i2s_sdata(i2s_sdata),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .underflow(underflow)
    );

`ifdef ADC_I2S_TX_LJ_EN
    localparam logic [63:0] LR_PAT = 64'h0000_0000_FFFF_FFFF;
`else
    localparam logic [63:0] LR_PAT = 64'h0000_0001_FFFF_FFFE;
`endif

    typedef struct {
        logic        do_push;
        logic [23:0] val;
        int          off;
        logic [23:0] exp_word;
        logic        exp_unf;
        logic [2:0]  exp_lvl;
    } fvec_t;

    int          nvec = 0;
    int          nerr = 0;
    int          cyc;
    int          bclk_err = 0;
    int          stray_unf = 0;
    int          mf;
    int          mb;
    logic [63:0] cap_sd [32];
    logic [63:0] cap_lr [32];
    logic        cap_unf [32];
    fvec_t       tbl [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        #1;
        if (rst_n && cyc >= 4 && (cyc - 4) % 4 == 0) begin
            mf = (cyc - 4) / 256;
            mb = ((cyc - 4) / 4) % 64;
            if (mf < 32) begin
                cap_sd[mf][63-mb] = i2s_sdata;
                cap_lr[mf][63-mb] = i2s_lrclk;
                if (mb == 0) cap_unf[mf] = underflow;
            end
        end
        if (rst_n && cyc >= 1) begin
            if (i2s_bclk !== 1'((cyc / 2) % 2)) bclk_err++;
            if (underflow && !(cyc >= 4 && (cyc - 4) % 256 == 0)) stray_unf++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    function automatic int fs(input int f);
        return 4 + 256 * f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_at(input int e, input logic [23:0] v);
        wait_edge(e - 1);
        sample_in    = v;
        sample_valid = 1'b1;
        wait_edge(e);
        sample_valid = 1'b0;
    endtask

    task automatic chk_frame(input int f, input logic [23:0] w, input logic unf);
        wait_edge(fs(f) + 253);
        chk($sformatf("frame%0d sdata", f), cap_sd[f], {w, 8'h00, w, 8'h00});
        chk($sformatf("frame%0d lrclk", f), cap_lr[f], LR_PAT);
        chk($sformatf("frame%0d underflow", f), 64'(cap_unf[f]), 64'(unf));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " bclk"},  64'(i2s_bclk),   64'd0);
        chk({tag, " lrclk"}, 64'(i2s_lrclk),  64'(LR_PAT[0]));
        chk({tag, " sdata"}, 64'(i2s_sdata),  64'd0);
        chk({tag, " level"}, 64'(fifo_level), 64'd0);
        chk({tag, " ovf"},   64'(overflow),   64'd0);
        chk({tag, " unf"},   64'(underflow),  64'd0);
    endtask

    task automatic chk_release(input string tag);
        wait_edge(1);
        chk({tag, " bclk@1"}, 64'(i2s_bclk), 64'd0);
        wait_edge(2);
        chk({tag, " bclk@2"}, 64'(i2s_bclk), 64'd1);
        wait_edge(4);
        chk({tag, " bclk@4"}, 64'(i2s_bclk), 64'd0);
        chk({tag, " unf@4"},  64'(underflow), 64'd1);
        wait_edge(5);
        chk({tag, " unf@5"},  64'(underflow), 64'd0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 24'hA5A5A5, 100, 24'h000000, 1'b1, 3'd1};
        tbl[1] = '{1'b1, 24'h800000, 100, 24'hA5A5A5, 1'b0, 3'd1};
        tbl[2] = '{1'b0, 24'h000000, 100, 24'h800000, 1'b0, 3'd0};
        tbl[3] = '{1'b0, 24'h000000, 100, 24'h800000, 1'b1, 3'd0};
        tbl[4] = '{1'b0, 24'h000000, 100, 24'h800000, 1'b1, 3'd0};
        tbl[5] = '{1'b0, 24'h000000, 100, 24'h800000, 1'b1, 3'd0};
        tbl[6] = '{1'b1, 24'h123456, 255, 24'h800000, 1'b1, 3'd1};
        tbl[7] = '{1'b0, 24'h000000, 100, 24'h123456, 1'b0, 3'd0};

        rst_n        = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        chk_release("release");

        for (int f = 0; f < 8; f++) begin
            if (tbl[f].do_push) push_at(fs(f) + tbl[f].off, tbl[f].val);
            else                wait_edge(fs(f) + tbl[f].off);
            chk($sformatf("frame%0d level", f), 64'(fifo_level), 64'(tbl[f].exp_lvl));
            chk_frame(f, tbl[f].exp_word, tbl[f].exp_unf);
        end

        // Fill to full, then push in the frame-start cycle while a pop happens
        for (int i = 0; i < 4; i++) push_at(fs(8) + 50 + i, 24'h100001 * 24'(i + 1));
        chk("fill level", 64'(fifo_level), 64'd4);
        chk("fill ovf",   64'(overflow),   64'd0);
        push_at(fs(9), 24'h500005);
        chk("full+pop level", 64'(fifo_level), 64'd4);
        chk("full+pop ovf",   64'(overflow),   64'd0);
        for (int f = 9; f < 14; f++) chk_frame(f, 24'h100001 * 24'(f - 8), 1'b0);
        chk_frame(14, 24'h500005, 1'b1);

        // Push into empty FIFO in the frame-start cycle
        push_at(fs(15), 24'h600006);
        chk("empty+pop unf",   64'(underflow),  64'd1);
        chk("empty+pop level", 64'(fifo_level), 64'd1);
        chk_frame(15, 24'h500005, 1'b1);
        chk_frame(16, 24'h600006, 1'b0);

        // Overflow: five back-to-back pushes mid-frame
        for (int i = 0; i < 5; i++) push_at(fs(17) + 50 + i, 24'h111111 * 24'(i + 1));
        chk("ovf level", 64'(fifo_level), 64'd4);
        chk("ovf flag",  64'(overflow),   64'd1);
        for (int f = 18; f < 22; f++) chk_frame(f, 24'h111111 * 24'(f - 17), 1'b0);

        // Mid-frame reset at bit 10 of the left slot with 3 samples queued
        for (int i = 0; i < 3; i++) push_at(fs(22) + 10 + i, 24'hABCDEF);
        wait_edge(fs(22) + 42);
        chk("pre-reset level", 64'(fifo_level), 64'd3);
        chk("pre-reset bclk",  64'(i2s_bclk),   64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        chk_release("re-release");
        chk_frame(0, 24'h000000, 1'b1);

        chk("bclk waveform errors", 64'(bclk_err), 64'd0);
        chk("stray underflow",      64'(stray_unf), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
